// File: rtl/card_dealer.sv
// Deals cards without replacement from a 52-card deck, using a seeded 16-bit LFSR
// to pick candidates and a linear scan as a fallback once too many picks are rejected.
module card_dealer #(
  parameter int WIDTH     = 12,
  parameter int MAX_TRIES = 64
) (
  input  logic             clk_50M,
  input  logic             i_Reset_n,
  input  logic [WIDTH-1:0] i_Seed,
  input  logic             i_Load,
  input  logic             i_Shuffle,
  input  logic             i_Draw,
  output logic [3:0]       o_Rank,
  output logic [1:0]       o_Suit,
  output logic [3:0]       o_Points,
  output logic             o_Valid,
  output logic             o_Busy,
  output logic [5:0]       o_Remaining,
  output logic             o_Empty
);

  typedef enum logic [1:0] {IDLE, SEARCH, SCAN, DONE} state_t;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [7:0]  LAST_TRY     = 8'(MAX_TRIES - 1);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [51:0] used_q, used_d;
  logic [5:0]  remaining_q, remaining_d;
  logic [7:0]  tries_q, tries_d;
  logic [5:0]  scan_ptr_q, scan_ptr_d;
  logic [3:0]  rank_q, rank_d;
  logic [1:0]  suit_q, suit_d;
  logic [3:0]  points_q, points_d;

  logic [15:0] seed_ext;
  logic [5:0]  cand;
  logic        cand_free;
  logic        scan_free;
  logic        accept;
  logic [5:0]  pick_idx;
  logic [3:0]  card_off;
  logic [3:0]  card_rank;
  logic [1:0]  card_suit;
  logic [3:0]  card_points;

  assign seed_ext  = 16'(i_Seed);
  assign cand      = lfsr_q[5:0];
  assign cand_free = (cand < 6'd52) && !used_q[cand];
  assign scan_free = (scan_ptr_q < 6'd52) && !used_q[scan_ptr_q];
  assign accept    = ((state_q == SEARCH) && cand_free) || ((state_q == SCAN) && scan_free);
  assign pick_idx  = (state_q == SCAN) ? scan_ptr_q : cand;

  // Index n maps to suit n/13 and rank n%13+1; face cards count as 10.
  always_comb begin
    card_suit = 2'd0;
    card_off  = pick_idx[3:0];
    if (pick_idx >= 6'd39) begin
      card_suit = 2'd3;
      card_off  = 4'(pick_idx - 6'd39);
    end else if (pick_idx >= 6'd26) begin
      card_suit = 2'd2;
      card_off  = 4'(pick_idx - 6'd26);
    end else if (pick_idx >= 6'd13) begin
      card_suit = 2'd1;
      card_off  = 4'(pick_idx - 6'd13);
    end
    card_rank   = card_off + 4'd1;
    card_points = (card_rank >= 4'd10) ? 4'd10 : card_rank;
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    used_d      = used_q;
    remaining_d = remaining_q;
    tries_d     = tries_q;
    scan_ptr_d  = scan_ptr_q;
    rank_d      = rank_q;
    suit_d      = suit_q;
    points_d    = points_q;

    case (state_q)
      IDLE: begin
        if (i_Draw && (remaining_q != 6'd0)) begin
          tries_d = 8'd0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (!cand_free) begin
          tries_d = tries_q + 8'd1;
          if (tries_q == LAST_TRY) begin
            state_d    = SCAN;
            scan_ptr_d = 6'd0;
          end
        end
      end
      SCAN: begin
        if (!scan_free) scan_ptr_d = scan_ptr_q + 6'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      used_d[pick_idx] = 1'b1;
      remaining_d      = remaining_q - 6'd1;
      rank_d           = card_rank;
      suit_d           = card_suit;
      points_d         = card_points;
      state_d          = DONE;
    end

    // A shuffle wins over everything and abandons any draw in flight.
    if (i_Shuffle) begin
      used_d      = '0;
      remaining_d = 6'd52;
      rank_d      = rank_q;
      suit_d      = suit_q;
      points_d    = points_q;
      state_d     = IDLE;
    end

    if (i_Load) lfsr_d = (seed_ext == 16'd0) ? LFSR_DEFAULT : seed_ext;
  end

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_DEFAULT;
      used_q      <= '0;
      remaining_q <= 6'd52;
      tries_q     <= 8'd0;
      scan_ptr_q  <= 6'd0;
      rank_q      <= 4'd0;
      suit_q      <= 2'd0;
      points_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      used_q      <= used_d;
      remaining_q <= remaining_d;
      tries_q     <= tries_d;
      scan_ptr_q  <= scan_ptr_d;
      rank_q      <= rank_d;
      suit_q      <= suit_d;
      points_q    <= points_d;
    end
  end

  assign o_Rank      = rank_q;
  assign o_Suit      = suit_q;
  assign o_Points    = points_q;
  assign o_Valid     = (state_q == DONE);
  assign o_Busy      = (state_q != IDLE);
  assign o_Remaining = remaining_q;
  assign o_Empty     = (remaining_q == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: a draw-level deck model checked every cycle, plus directed
// scenarios with hand-computed expectations and a MAX_TRIES=1 instance for the scan path.
module tb_card_dealer;

  localparam int          WIDTH     = 12;
  localparam int          MAX_TRIES = 64;
  localparam logic [15:0] ACE       = 16'hACE1;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic             rst_n, load, shuffle, draw;
  logic [WIDTH-1:0] seed;
  logic [3:0]       rank, points;
  logic [1:0]       suit;
  logic             valid, busy, empty;
  logic [5:0]       remaining;

  logic             d1_load, d1_shuffle, d1_draw;
  logic [WIDTH-1:0] d1_seed;
  logic [3:0]       d1_rank, d1_points;
  logic [1:0]       d1_suit;
  logic             d1_valid, d1_busy, d1_empty;
  logic [5:0]       d1_remaining;

  card_dealer #(.WIDTH(WIDTH), .MAX_TRIES(MAX_TRIES)) dut (
    .clk_50M(clk), .i_Reset_n(rst_n), .i_Seed(seed), .i_Load(load),
    .i_Shuffle(shuffle), .i_Draw(draw), .o_Rank(rank), .o_Suit(suit),
    .o_Points(points), .o_Valid(valid), .o_Busy(busy),
    .o_Remaining(remaining), .o_Empty(empty)
  );

  card_dealer #(.WIDTH(WIDTH), .MAX_TRIES(1)) dut1 (
    .clk_50M(clk), .i_Reset_n(rst_n), .i_Seed(d1_seed), .i_Load(d1_load),
    .i_Shuffle(d1_shuffle), .i_Draw(d1_draw), .o_Rank(d1_rank), .o_Suit(d1_suit),
    .o_Points(d1_points), .o_Valid(d1_valid), .o_Busy(d1_busy),
    .o_Remaining(d1_remaining), .o_Empty(d1_empty)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Packed {rank, suit, points} for deck index n.
  function automatic logic [9:0] card_of(input int n);
    int r;
    r = n % 13 + 1;
    return {4'(r), 2'(n / 13), 4'((r >= 10) ? 10 : r)};
  endfunction

  // Whole-draw outcome: chosen index, LFSR steps consumed, and edges until the accept.
  function automatic void plan(input logic [15:0] lf, input logic [51:0] used, input int maxt,
                               output int idx, output int s, output int t, output logic [15:0] lf_out);
    int cand;
    lf_out = lf;
    idx    = -1;
    s      = 0;
    t      = 0;
    for (int i = 0; i < maxt; i++) begin
      cand   = int'(lf_out[5:0]);
      lf_out = lfsr_next(lf_out);
      s++;
      if (cand < 52 && !used[cand]) begin
        idx = cand;
        t   = s;
        return;
      end
    end
    for (int j = 0; j < 52; j++) begin
      if (!used[j]) begin
        idx = j;
        t   = maxt + j + 1;
        return;
      end
    end
  endfunction

  // Deck model for the main instance, advanced once per clock edge.
  logic [15:0]      m_lfsr = ACE;
  logic [51:0]      m_used = '0;
  int               m_rem = 52;
  bit               m_busy = 1'b0;
  int               m_e, m_idx, m_s, m_t;
  logic [9:0]       m_card = '0;
  logic             e_valid = 1'b0;
  logic [15:0]      plan_lf;
  logic             s_rst, s_load, s_shuf, s_draw;
  logic [WIDTH-1:0] s_seed;

  // Sample inputs at the edge, update the model just after it, then compare.
  initial begin : compare
    bit start;
    forever begin
      @(posedge clk);
      s_rst  = rst_n;
      s_load = load;
      s_shuf = shuffle;
      s_draw = draw;
      s_seed = seed;
      #1;
      start = 1'b0;
      if (s_rst !== 1'b1) begin
        m_lfsr  = ACE;
        m_used  = '0;
        m_rem   = 52;
        m_busy  = 1'b0;
        m_card  = '0;
        e_valid = 1'b0;
      end else begin
        e_valid = 1'b0;
        if (m_busy) begin
          m_e++;
          if (m_e <= m_s) m_lfsr = lfsr_next(m_lfsr);
          if (m_e <= m_t) begin
            if (s_shuf) begin
              m_busy = 1'b0;
              m_used = '0;
              m_rem  = 52;
            end else if (m_e == m_t) begin
              m_used[m_idx] = 1'b1;
              m_rem--;
              m_card  = card_of(m_idx);
              e_valid = 1'b1;
            end
          end else begin
            m_busy = 1'b0;
            if (s_shuf) begin
              m_used = '0;
              m_rem  = 52;
            end
          end
        end else if (s_shuf) begin
          m_used = '0;
          m_rem  = 52;
        end else if (s_draw && m_rem > 0) begin
          start = 1'b1;
        end
        if (s_load) m_lfsr = (s_seed == '0) ? ACE : 16'(s_seed);
        if (start) begin
          plan(m_lfsr, m_used, MAX_TRIES, m_idx, m_s, m_t, plan_lf);
          m_busy = 1'b1;
          m_e    = 0;
        end
      end
      checkOutput("valid", valid, e_valid);
      checkOutput("busy", busy, m_busy);
      checkOutput("remaining", remaining, m_rem);
      checkOutput("empty", empty, m_rem == 0);
      checkOutput("card", {rank, suit, points}, m_card);
    end
  end

  task automatic applyStimulus(input logic d, input logic s, input logic l, input logic [WIDTH-1:0] sd);
    @(negedge clk);
    draw = d; shuffle = s; load = l; seed = sd;
    @(negedge clk);
    draw = 1'b0; shuffle = 1'b0; load = 1'b0; seed = '0;
  endtask

  task automatic waitValid(input bit which, input int maxc, output int cycles);
    cycles = 0;
    while (((which ? d1_valid : valid) !== 1'b1) && cycles < maxc) begin
      @(negedge clk);
      cycles++;
    end
    if ((which ? d1_valid : valid) !== 1'b1)
      checkOutput(which ? "d1_valid_timeout" : "valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          cyc, idx, s, t;
    bit          seen[52];
    logic [15:0] d1_lfsr, nxt;
    logic [51:0] d1_used;

    rst_n = 1'b0; load = 1'b0; shuffle = 1'b0; draw = 1'b0; seed = '0;
    d1_load = 1'b0; d1_shuffle = 1'b0; d1_draw = 1'b0; d1_seed = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_rank", rank, 0);
    checkOutput("rst_remaining", remaining, 52);
    checkOutput("rst_busy_valid", {busy, valid, empty}, 0);
    rst_n = 1'b1;

    // First draw after reset: ACE1 low bits give index 33 -> 8 of suit 2.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    waitValid(1'b0, 200, cyc);
    checkOutput("first_latency", cyc, 1);
    checkOutput("first_card", {rank, suit, points}, {4'd8, 2'd2, 4'd8});
    checkOutput("first_remaining", remaining, 51);
    @(negedge clk);

    // Seed 0 falls back to ACE1, so the same card comes out again.
    applyStimulus(1'b0, 1'b1, 1'b1, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    waitValid(1'b0, 200, cyc);
    checkOutput("seed0_card", {rank, suit, points}, {4'd8, 2'd2, 4'd8});
    checkOutput("seed0_remaining", remaining, 51);
    @(negedge clk);

    // Shuffle right behind a draw aborts it and leaves the old card showing.
    draw = 1'b1;
    @(negedge clk);
    draw = 1'b0; shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    checkOutput("abort_remaining", remaining, 52);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_card", {rank, suit, points}, {4'd8, 2'd2, 4'd8});
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_no_valid", valid, 0);
    end

    // Reset during SEARCH clears outputs immediately.
    draw = 1'b1;
    @(negedge clk);
    draw = 1'b0; rst_n = 1'b0;
    #1;
    checkOutput("midrst_card", {rank, suit, points}, 0);
    checkOutput("midrst_flags", {valid, busy, empty}, 0);
    checkOutput("midrst_remaining", remaining, 52);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_no_valid", valid, 0);
    end

    // Empty the deck from a fresh seed, then one draw too many.
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h5A3);
    foreach (seen[i]) seen[i] = 1'b0;
    for (int n = 0; n < 52; n++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      waitValid(1'b0, 200, cyc);
      idx = int'(suit) * 13 + int'(rank) - 1;
      if (idx >= 0 && idx < 52) begin
        checkOutput("distinct", seen[idx], 0);
        seen[idx] = 1'b1;
      end else begin
        checkOutput("card_range", idx, 0);
      end
      @(negedge clk);
    end
    checkOutput("deck_empty", {remaining, empty}, {6'd0, 1'b1});
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    repeat (3) begin
      checkOutput("overdraw_quiet", {valid, busy}, 0);
      @(negedge clk);
    end

    // MAX_TRIES=1 instance: every draw matches the planned index and latency.
    d1_lfsr = ACE;
    d1_used = '0;
    for (int n = 0; n < 52; n++) begin
      plan(d1_lfsr, d1_used, 1, idx, s, t, nxt);
      @(negedge clk);
      d1_draw = 1'b1;
      @(negedge clk);
      d1_draw = 1'b0;
      waitValid(1'b1, 60, cyc);
      checkOutput("d1_latency", cyc, t);
      checkOutput("d1_card", {d1_rank, d1_suit, d1_points}, card_of(idx));
      if (idx >= 0) d1_used[idx] = 1'b1;
      d1_lfsr = nxt;
      if (n == 51) checkOutput("d1_last_within_53", cyc <= 53, 1);
    end
    @(negedge clk);
    checkOutput("d1_empty", {d1_remaining, d1_empty, d1_busy}, {6'd0, 1'b1, 1'b0});

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
# card_dealer

Draws cards without replacement from a 52-card deck for the BlackJack game. It sits directly downstream of the free-running counter, which runs while the player holds the reset button. The counter value is latched here as the seed of a 16-bit LFSR. Each draw request returns one unused card (rank, suit, BlackJack points) and marks it dealt until the next shuffle.

## Interface
- WIDTH, 12, width of the seed input from the counter; legal range 1..16.
- MAX_TRIES, 64, number of rejected LFSR candidates before falling back to a linear scan; legal range 1..255.

Ports:
- clk_50M  in  1  50 MHz system clock; all state on the rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Seed  in  WIDTH  seed value (counter output), zero-extended to 16 bits.
- i_Load  in  1  single-cycle strobe; loads the seed into the LFSR.
- i_Shuffle  in  1  single-cycle strobe; returns all 52 cards to the deck.
- i_Draw  in  1  single-cycle strobe; requests one card.
- o_Rank  out  4  1..13 (A=1, J=11, Q=12, K=13); 0 until the first card.
- o_Suit  out  2  0..3.
- o_Points  out  4  BlackJack value: A=1, 2..10 face value, J/Q/K=10.
- o_Valid  out  1  one-cycle pulse; the card outputs are new.
- o_Busy  out  1  a draw is in progress.
- o_Remaining  out  6  cards left in the deck, 0..52.
- o_Empty  out  1  high when o_Remaining==0.

## Operation
- State: lfsr[15:0], used[51:0], remaining[5:0], tries[7:0], scan_ptr[5:0], FSM {IDLE, SEARCH, SCAN, DONE}.
- LFSR: Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Step: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - i_Load: lfsr <= zero-extended i_Seed, or 16'hACE1 if the seed is 0. The LFSR is never all-zero.
  - i_Load overrides the step in the same cycle and is accepted in any state.
- Candidate: cand = lfsr[5:0]. It is accepted when cand<52 and used[cand]==0.
- Card mapping for index n:
  - rank = n%13 + 1
  - suit = n/13
  - points = (rank>=10) ? 10 : rank
- IDLE:
  - i_Shuffle: clears used, remaining <= 52, stays in IDLE.
  - Else i_Draw with remaining>0: tries <= 0, go to SEARCH.
  - i_Draw with remaining==0: ignored; no o_Valid, no state change.
- SEARCH, each cycle:
  - Evaluate cand on the current lfsr, then step the lfsr.
  - Accept: set used[cand], remaining--, register the card outputs, go to DONE.
  - Reject: tries++. When tries reaches MAX_TRIES-1 on a reject, go to SCAN with scan_ptr <= 0.
- SCAN, each cycle:
  - If used[scan_ptr]==0: accept scan_ptr exactly as above, go to DONE.
  - Else scan_ptr++. A free card always exists, so the scan ends within 52 cycles.
- DONE: lasts one cycle, then goes to IDLE.
- Priority in any state: i_Shuffle > i_Draw.
  - i_Shuffle in SEARCH/SCAN aborts the draw: no o_Valid, used cleared, remaining=52, next state IDLE, card outputs keep their old values.
  - i_Shuffle in DONE: the card just drawn still pulses o_Valid, but its used bit and the remaining decrement are overridden by the clear.
- i_Draw while o_Busy is high is ignored; it is not queued.
- Card outputs hold their last value until the next accept.

## Timing
- Reset values (asynchronous, on i_Reset_n low):
  - FSM=IDLE, lfsr=16'hACE1, used=0, remaining=52
  - o_Rank=0, o_Suit=0, o_Points=0
  - o_Valid=0, o_Busy=0, o_Remaining=52, o_Empty=0
- Reset asserted mid-draw aborts the draw; no o_Valid is produced.
- i_Draw sampled at edge k puts the FSM in SEARCH during cycle k+1.
- Best case: accept at edge k+1, so o_Valid is high in cycle k+2 with the card outputs already updated.
- Worst case: MAX_TRIES SEARCH cycles plus 52 SCAN cycles, then 1 DONE cycle.
- o_Busy is high in SEARCH, SCAN and DONE.
- o_Remaining and o_Empty are registered and update in the same cycle o_Valid rises.
- Earliest next draw: i_Draw in the cycle after DONE, when o_Busy is low.

## Test plan
- Reset, no i_Load, one i_Draw → o_Valid 2 cycles later with index 33: o_Rank=8, o_Suit=2, o_Points=8, o_Remaining=51.
- i_Load with i_Seed=0, then draw → identical result to the first scenario, since seed 0 maps to 16'hACE1.
- 52 consecutive draws from any seed → 52 distinct (suit,rank) pairs with o_Valid each, o_Remaining=0, o_Empty=1. A 53rd i_Draw → no o_Valid, o_Busy stays 0.
- MAX_TRIES=1, 51 cards drawn → the last draw still returns the only free index within 53 cycles of i_Draw.
- i_Shuffle one cycle after i_Draw → no o_Valid, o_Remaining=52, FSM in IDLE; card outputs unchanged from before.
- i_Reset_n pulsed low during SEARCH → all outputs at reset values immediately; no o_Valid afterwards.
